// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for pwm_gen: steps h_time toward a target duty, one step every
// cfg_hold frames, changing en/period/h_time only on frame boundaries.
module pwm_ramp_ctrl #(
  parameter int W      = 16,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [W-1:0]      cfg_period,
  input  logic [W-1:0]      cfg_duty,
  input  logic [W-1:0]      cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              start,
  input  logic              stop,
  output logic              pwm_en,
  output logic [W-1:0]      pwm_period,
  output logic [W-1:0]      pwm_h_time,
  output logic              frame_end,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RAMP = 2'd2, STEADY = 2'd3} state_t;

  state_t            r_state;
  logic [W-1:0]      r_mcnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_cfg_loaded;
  logic              r_stop_pend;
  logic              r_apply_pend;
  logic [W-1:0]      r_sh_period;
  logic [W-1:0]      r_sh_duty;
  logic [W-1:0]      r_sh_step;
  logic [HOLD_W-1:0] r_sh_hold;
  logic              r_pwm_en;
  logic [W-1:0]      r_pwm_period;
  logic [W-1:0]      r_pwm_h_time;
  logic              r_done;

  logic              w_frame_end;
  logic              w_cfg_fire;
  logic [W-1:0]      w_cl_period;
  logic [W-1:0]      w_cl_duty;
  logic [W-1:0]      w_cl_step;
  logic [HOLD_W-1:0] w_cl_hold;
  logic [W:0]        w_sum;
  logic [W:0]        w_dif;
  logic [W-1:0]      w_next_h;
  logic [W-1:0]      w_apply_h;
  logic              w_hold_hit;

  // Mirror of pwm_gen's counter: same reset, same wrap rule, so frames line up.
  assign w_frame_end = (r_mcnt >= (r_pwm_period - W'(1)));

  // cfg_valid/cfg_ready: a config transfers on a clk edge where both are high;
  // cfg_ready never looks at cfg_valid, and stop in STEADY withholds it.
  assign cfg_ready  = !r_stop_pend &&
                      ((r_state == IDLE) || ((r_state == STEADY) && !stop));
  assign w_cfg_fire = cfg_valid && cfg_ready;

  assign w_cl_period = (cfg_period < W'(2)) ? W'(2) : cfg_period;
  assign w_cl_duty   = (cfg_duty > w_cl_period) ? w_cl_period : cfg_duty;
  assign w_cl_step   = (cfg_step == '0) ? W'(1) : cfg_step;
  assign w_cl_hold   = (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;

  assign w_sum      = {1'b0, r_pwm_h_time} + {1'b0, r_sh_step};
  assign w_dif      = {1'b0, r_pwm_h_time} - {1'b0, r_sh_step};
  assign w_apply_h  = (r_pwm_h_time > r_sh_period) ? r_sh_period : r_pwm_h_time;
  assign w_hold_hit = ((HOLD_W+1)'(r_hold_cnt) + (HOLD_W+1)'(1)) == (HOLD_W+1)'(r_sh_hold);

  // One step toward the target, landing exactly on it rather than overshooting.
  always_comb begin
    w_next_h = r_sh_duty;
    if (r_pwm_h_time < r_sh_duty) begin
      if (w_sum < {1'b0, r_sh_duty}) w_next_h = w_sum[W-1:0];
    end else if (r_pwm_h_time > r_sh_duty) begin
      if (!w_dif[W] && (w_dif > {1'b0, r_sh_duty})) w_next_h = w_dif[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mcnt       <= '0;
      r_hold_cnt   <= '0;
      r_cfg_loaded <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_apply_pend <= 1'b0;
      r_sh_period  <= W'(2);
      r_sh_duty    <= '0;
      r_sh_step    <= W'(1);
      r_sh_hold    <= HOLD_W'(1);
      r_pwm_en     <= 1'b0;
      r_pwm_period <= W'(2);
      r_pwm_h_time <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mcnt <= w_frame_end ? '0 : r_mcnt + W'(1);
      if (w_cfg_fire) begin
        r_sh_period  <= w_cl_period;
        r_sh_duty    <= w_cl_duty;
        r_sh_step    <= w_cl_step;
        r_sh_hold    <= w_cl_hold;
        r_cfg_loaded <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!w_cfg_fire && !stop && start && r_cfg_loaded) r_state <= ARM;
        end
        ARM: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_frame_end) begin
            r_pwm_period <= r_sh_period;
            r_pwm_h_time <= '0;
            r_pwm_en     <= 1'b1;
            r_hold_cnt   <= '0;
            if (r_sh_duty == '0) begin
              r_done  <= 1'b1;
              r_state <= STEADY;
            end else begin
              r_state <= RAMP;
            end
          end
        end
        RAMP, STEADY: begin
          if (stop || r_stop_pend) begin
            if (w_frame_end) begin
              r_pwm_en     <= 1'b0;
              r_pwm_h_time <= '0;
              r_stop_pend  <= 1'b0;
              r_apply_pend <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_stop_pend <= 1'b1;
            end
          end else if (r_state == STEADY) begin
            if (w_cfg_fire) begin
              r_apply_pend <= 1'b1;
              r_state      <= RAMP;
            end
          end else if (w_frame_end) begin
            // A config taken in STEADY takes effect here; stepping resumes after.
            if (r_apply_pend) begin
              r_apply_pend <= 1'b0;
              r_pwm_period <= r_sh_period;
              r_pwm_h_time <= w_apply_h;
              r_hold_cnt   <= '0;
              if (w_apply_h == r_sh_duty) begin
                r_done  <= 1'b1;
                r_state <= STEADY;
              end
            end else if (w_hold_hit) begin
              r_hold_cnt   <= '0;
              r_pwm_h_time <= w_next_h;
              if (w_next_h == r_sh_duty) begin
                r_done  <= 1'b1;
                r_state <= STEADY;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pwm_en     = r_pwm_en;
  assign pwm_period = r_pwm_period;
  assign pwm_h_time = r_pwm_h_time;
  assign frame_end  = w_frame_end;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: expected (en, period, h_time, frame gap)
// tuples are queued with the stimulus and popped whenever the outputs change.
module tb_pwm_ramp_ctrl;
  localparam int W      = 16;
  localparam int HOLD_W = 8;
  localparam int TW     = 2*W + 1;
  localparam int EW     = TW + 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [W-1:0]      cfg_period;
  logic [W-1:0]      cfg_duty;
  logic [W-1:0]      cfg_step;
  logic [HOLD_W-1:0] cfg_hold;
  logic              start;
  logic              stop;
  logic              pwm_en;
  logic [W-1:0]      pwm_period;
  logic [W-1:0]      pwm_h_time;
  logic              frame_end;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  pwm_ramp_ctrl #(.W(W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_step(cfg_step), .cfg_hold(cfg_hold),
    .start(start), .stop(stop),
    .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_h_time(pwm_h_time),
    .frame_end(frame_end), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int fe_cnt = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [TW-1:0] prev_tup;
  logic [TW-1:0] cur_tup;
  logic          prev_fe;
  logic          last_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic en, input logic [W-1:0] p, input logic [W-1:0] h,
                          input logic [7:0] gap);
    exp_q.push_back({gap, en, p, h});
  endtask

  // scoreboard / monitor
  always @(posedge clk) last_rst <= rst_n;

  always @(negedge clk) begin
    cur_tup = {pwm_en, pwm_period, pwm_h_time};
    if (cur_tup !== prev_tup) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_change obs=%0h exp=none", cur_tup);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tuple", 64'(cur_tup), 64'(e[TW-1:0]));
        if (e[EW-1 -: 8] != 8'd0) chk("frame_gap", 64'(fe_cnt), 64'(e[EW-1 -: 8]));
      end
      if (last_rst === 1'b1) chk("frame_align", 64'(prev_fe), 64'(1));
      fe_cnt = 0;
    end
    prev_tup = cur_tup;
    if (last_rst !== 1'b1) begin
      cyc = 1;
      fe_cnt = 0;
    end else begin
      cyc = cyc + 1;
      if (frame_end === 1'b1) begin
        chk("frame_len", 64'(cyc), 64'(pwm_period));
        cyc = 0;
        fe_cnt++;
      end
    end
    prev_fe = frame_end;
    if (done === 1'b1) done_cnt++;
  end

  // driver tasks
  task automatic send_cfg(input logic [W-1:0] p, input logic [W-1:0] d,
                          input logic [W-1:0] s, input logic [HOLD_W-1:0] h);
    int n;
    n = 0;
    @(negedge clk); #1;
    cfg_valid = 1'b1; cfg_period = p; cfg_duty = d; cfg_step = s; cfg_hold = h;
    while (!cfg_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("cfg_handshake", 64'(cfg_ready), 64'(1));
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_period = '0; cfg_duty = '0; cfg_step = '0; cfg_hold = '0;
    push_exp(1'b0, 16'd2, 16'd0, 8'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    chk("rst_ready", 64'(cfg_ready), 64'(1));
    chk("rst_frame_end", 64'(frame_end), 64'(0));
    rst_n = 1'b1;

    // 1: up-ramp from reset
    push_exp(1'b1, 16'd10, 16'd0, 8'd0);
    push_exp(1'b1, 16'd10, 16'd2, 8'd1);
    push_exp(1'b1, 16'd10, 16'd4, 8'd1);
    push_exp(1'b1, 16'd10, 16'd6, 8'd1);
    send_cfg(16'd10, 16'd6, 16'd2, 8'd1);
    pulse_start();
    wait_drain("t1_drain", 300);
    chk("t1_done", 64'(done_cnt), 64'(1));
    chk("t1_state", 64'(dbg_state), 64'(3));
    chk("t1_busy", 64'(busy), 64'(1));

    // 2: down-ramp, 3 frames per step, saturating at 1
    push_exp(1'b1, 16'd10, 16'd4, 8'd0);
    push_exp(1'b1, 16'd10, 16'd2, 8'd3);
    push_exp(1'b1, 16'd10, 16'd1, 8'd3);
    send_cfg(16'd10, 16'd1, 16'd2, 8'd3);
    wait_drain("t2_drain", 500);
    chk("t2_done", 64'(done_cnt), 64'(2));

    // 3: back to 6, then period change to 4 clamps h_time, ramps to 3
    push_exp(1'b1, 16'd10, 16'd6, 8'd0);
    send_cfg(16'd10, 16'd6, 16'd5, 8'd1);
    wait_drain("t3a_drain", 300);
    chk("t3a_done", 64'(done_cnt), 64'(3));
    push_exp(1'b1, 16'd4, 16'd4, 8'd0);
    push_exp(1'b1, 16'd4, 16'd3, 8'd1);
    send_cfg(16'd4, 16'd3, 16'd1, 8'd1);
    wait_drain("t3b_drain", 300);
    chk("t3b_done", 64'(done_cnt), 64'(4));
    chk("t3b_state", 64'(dbg_state), 64'(3));

    // 4: stop at mcnt=2 mid-ramp; outputs hold until the frame ends
    push_exp(1'b1, 16'd8, 16'd3, 8'd0);
    push_exp(1'b1, 16'd8, 16'd4, 8'd1);
    send_cfg(16'd8, 16'd7, 16'd1, 8'd1);
    wait_drain("t4a_drain", 300);
    push_exp(1'b0, 16'd8, 16'd0, 8'd0);
    @(negedge clk); @(negedge clk); #1 stop = 1'b1;
    @(negedge clk); #1 stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_en", 64'(pwm_en), 64'(1));
      chk("t4_hold_h", 64'(pwm_h_time), 64'(4));
      chk("t4_ready_low", 64'(cfg_ready), 64'(0));
      chk("t4_busy", 64'(busy), 64'(1));
      @(negedge clk); #1;
    end
    wait_drain("t4b_drain", 50);
    chk("t4_state", 64'(dbg_state), 64'(0));
    chk("t4_ready", 64'(cfg_ready), 64'(1));
    chk("t4_done", 64'(done_cnt), 64'(4));

    // 5: clamps period 0->2, step 0->1, hold 0->1, duty 9->2
    push_exp(1'b1, 16'd2, 16'd0, 8'd0);
    push_exp(1'b1, 16'd2, 16'd1, 8'd1);
    push_exp(1'b1, 16'd2, 16'd2, 8'd1);
    send_cfg(16'd0, 16'd9, 16'd0, 8'd0);
    pulse_start();
    wait_drain("t5_drain", 300);
    chk("t5_done", 64'(done_cnt), 64'(5));

    // 6: reset mid-ramp together with stop|cfg|start
    push_exp(1'b1, 16'd10, 16'd2, 8'd0);
    push_exp(1'b1, 16'd10, 16'd3, 8'd2);
    send_cfg(16'd10, 16'd9, 16'd1, 8'd2);
    wait_drain("t6a_drain", 300);
    push_exp(1'b0, 16'd2, 16'd0, 8'd0);
    @(negedge clk); #1;
    rst_n = 1'b0; stop = 1'b1; start = 1'b1; cfg_valid = 1'b1;
    cfg_period = 16'd5; cfg_duty = 16'd5; cfg_step = 16'd5; cfg_hold = 8'd5;
    @(negedge clk); #1;
    rst_n = 1'b1; stop = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    chk("t6_rst_state", 64'(dbg_state), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_done", 64'(done), 64'(0));
    chk("t6_rst_ready", 64'(cfg_ready), 64'(1));
    wait_drain("t6b_drain", 20);
    pulse_start();
    repeat (8) @(negedge clk);
    chk("t6_start_unloaded", 64'(busy), 64'(0));
    push_exp(1'b1, 16'd6, 16'd0, 8'd0);
    push_exp(1'b1, 16'd6, 16'd3, 8'd1);
    send_cfg(16'd6, 16'd3, 16'd3, 8'd1);
    pulse_start();
    wait_drain("t6c_drain", 300);
    chk("t6c_done", 64'(done_cnt), 64'(6));
    push_exp(1'b0, 16'd6, 16'd0, 8'd0);
    stop = 1'b1; start = 1'b1; cfg_valid = 1'b1;
    cfg_period = 16'd4; cfg_duty = 16'd1; cfg_step = 16'd1; cfg_hold = 8'd1;
    #1;
    chk("t6_stop_beats_cfg", 64'(cfg_ready), 64'(0));
    @(negedge clk); #1;
    stop = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    wait_drain("t6d_drain", 50);
    chk("t6d_state", 64'(dbg_state), 64'(0));
    push_exp(1'b1, 16'd6, 16'd0, 8'd0);
    push_exp(1'b1, 16'd6, 16'd3, 8'd1);
    pulse_start();
    wait_drain("t6e_drain", 300);
    chk("t6e_done", 64'(done_cnt), 64'(7));

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
